regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the register file's single write port between NUM_REQ writeback sources
//   (e.g. ALU, load unit, CSR unit) using round-robin arbitration.
//   Grants at most one request per cycle with a valid/ready handshake.
//   Registers the winner onto the regfile write_enable/write_addr/write_data inputs.
//   The same registered bus also drives the decode-stage bypass.
// PARAMETERS
//   NUM_REQ  2   number of writeback requesters (2..4)
//   ADDR_W   5   register address width
//   DATA_W   32  write data width
// PORTS
//   clk           in   1                clock; all state updates on posedge
//   rst           in   1                synchronous reset, active-high
//   stall         in   1                1 = grant nothing this cycle
//   req_valid     in   NUM_REQ          per-requester write request
//   req_addr      in   NUM_REQ*ADDR_W   flat; requester i at [i*ADDR_W +: ADDR_W]
//   req_data      in   NUM_REQ*DATA_W   flat; requester i at [i*DATA_W +: DATA_W]
//   req_ready     out  NUM_REQ          one-hot/zero grant, combinational
//   write_enable  out  1                to regfile write_enable (registered)
//   write_addr    out  ADDR_W           to regfile write_addr (registered)
//   write_data    out  DATA_W           to regfile write_data (registered)
//   write_src     out  clog2(NUM_REQ)   index of the requester now being written (registered)
// BEHAVIOUR
// - Handshake
//   - Transfer on requester i when req_valid[i] && req_ready[i].
//   - Requester holds valid/addr/data stable until it sees ready.
//   - req_ready never depends on req_addr/req_data; it is never asserted when req_valid[i]=0.
// - Arbitration
//   - Combinational round-robin from pointer ptr: first i with req_valid[i]=1,
//     searching ptr, ptr+1, ..., NUM_REQ-1, 0, ... (wrap).
//   - stall=1 or no valid -> req_ready=0, ptr unchanged.
// - Pointer
//   - On a grant to i: ptr <= (i==NUM_REQ-1) ? 0 : i+1.
//   - A requester continuously valid waits at most NUM_REQ-1 grants.
// - Latency
//   - Exactly 1 cycle: a handshake in cycle N gives the write on the bus in cycle N+1.
//   - The regfile commits it at the end of N+1.
//   - Sustained throughput is 1 write/cycle.
// - Output stage, cycle after a grant to i
//   - write_addr <= req_addr[i], write_data <= req_data[i], write_src <= i.
//   - write_enable <= (req_addr[i] != 0).
// - x0 writes
//   - Granted and handshaken normally; they consume the grant and advance ptr.
//   - They never assert write_enable.
// - Cycle without a grant: write_enable <= 0; write_addr/write_data/write_src hold.
// - Same address from two requesters: serialized in grant order; the later grant wins in the regfile.
// - Reset (synchronous rst=1)
//   - ptr=0, write_enable=0, write_addr=0, write_data=0, write_src=0.
//   - req_ready=0 while rst=1.
//   - A handshake in the cycle rst is asserted is discarded.
//   - First grant possible in the first cycle with rst=0.
// - Bypass: write_enable/write_addr/write_data double as the decode-stage bypass bus.
//   Readers compare write_addr while write_enable=1.
// TESTING
// 1 Reset: rst=1 for 2 cycles with req_valid=2'b11
//   -> req_ready=0; write_enable=0, write_addr=0, write_data=0, ptr=0.
// 2 Single req: req0 addr=5 data=32'hDEADBEEF for 1 cycle
//   -> req_ready=2'b01 that cycle;
//   -> next cycle write_enable=1, write_addr=5, write_data=DEADBEEF, write_src=0;
//   -> following cycle write_enable=0.
// 3 Contention: req0 (addr 3) and req1 (addr 4) held valid from reset
//   -> grants 0,1,0,1 on consecutive cycles;
//   -> write_addr sequence 3,4,3,4 with write_enable=1 every cycle.
// 4 x0 drop: req1 addr=0 data=1
//   -> req_ready[1]=1; next cycle write_enable=0; ptr advances to 0.
// 5 Stall: both valid, stall=1 for 3 cycles
//   -> req_ready=0 and write_enable=0 for those cycles, ptr unchanged;
//   -> on release, grant goes to the ptr requester.
// 6 Reset mid-op: continuous contention, rst=1 for 1 cycle after grant to req0
//   -> next cycle write_enable=0;
//   -> first grant after release is req0 (ptr=0).

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NUM_REQ
// writeback sources; the registered winner also feeds the decode-stage bypass.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       write_enable,
   output logic [ADDR_W-1:0]          write_addr,
   output logic [DATA_W-1:0]          write_data,
   output logic [$clog2(NUM_REQ)-1:0] write_src
);

   localparam int SRC_W = $clog2(NUM_REQ);

   logic [SRC_W-1:0]  ptr_q, ptr_d;
   logic              grant_vld;
   logic [SRC_W-1:0]  grant_idx;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] data_sel;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [SRC_W-1:0]  ws_q, ws_d;

   // Search ptr, ptr+1, ... with wrap; the first valid requester wins.
   always_comb begin
      int idx;
      logic [SRC_W-1:0] idx_s;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_s = SRC_W'(idx);
         if (!grant_vld && req_valid[idx_s]) begin
            grant_vld = 1'b1;
            grant_idx = idx_s;
         end
      end
      if (rst || stall) grant_vld = 1'b0;
   end

   assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
   assign addr_sel  = req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign data_sel  = req_data[grant_idx*DATA_W +: DATA_W];

   always_comb begin
      ptr_d = ptr_q;
      we_d  = 1'b0;
      wa_d  = wa_q;
      wd_d  = wd_q;
      ws_d  = ws_q;
      if (grant_vld) begin
         ptr_d = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
         // x0 writes still consume the grant but never reach the regfile.
         we_d  = (addr_sel != '0);
         wa_d  = addr_sel;
         wd_d  = data_sel;
         ws_d  = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         we_q  <= 1'b0;
         wa_q  <= '0;
         wd_q  <= '0;
         ws_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         we_q  <= we_d;
         wa_q  <= wa_d;
         wd_q  <= wd_d;
         ws_q  <= ws_d;
      end
   end

   assign write_enable = we_q;
   assign write_addr   = wa_q;
   assign write_data   = wd_q;
   assign write_src    = ws_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a round-robin reference model.
module tb_regfile_wb_arbiter;

   localparam int NR = 2;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int SW = $clog2(NR);

   logic             clk;
   logic             rst;
   logic             stall;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             write_enable;
   logic [AW-1:0]    write_addr;
   logic [DW-1:0]    write_data;
   logic [SW-1:0]    write_src;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int            m_ptr = 0;
   logic          m_we  = 1'b0;
   logic [AW-1:0] m_wa  = '0;
   logic [DW-1:0] m_wd  = '0;
   int            m_ws  = 0;

   regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .write_src(write_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_grant();
      int i;
      if (rst || stall) return -1;
      for (int k = 0; k < NR; k++) begin
         i = (m_ptr + k) % NR;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] model_ready();
      int g;
      g = model_grant();
      return (g < 0) ? '0 : (NR'(1) << g);
   endfunction

   // Advance one clock and update the model from the inputs present at the edge.
   task automatic tick();
      int g;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      g = model_grant();
      a = '0;
      d = '0;
      if (g >= 0) begin
         a = req_addr[g*AW +: AW];
         d = req_data[g*DW +: DW];
      end
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_ws = 0;
      end else if (g >= 0) begin
         m_we = (a != '0); m_wa = a; m_wd = d; m_ws = g;
         m_ptr = (g == NR-1) ? 0 : g + 1;
      end else begin
         m_we = 1'b0;
      end
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; req_valid = '1;
      for (int c = 0; c < 2; c++) begin
         #2;
         n_vec++;
         if (req_ready !== '0) begin
            n_err++; $display("FAIL reset_ready: req_ready=%b expected 0", req_ready);
         end
         tick();
      end
      #2;
      n_vec++;
      if (write_enable !== 1'b0 || write_addr !== '0 || write_data !== '0 || write_src !== '0) begin
         n_err++;
         $display("FAIL reset_bus: we=%b wa=%0d wd=%h ws=%0d expected all 0",
                  write_enable, write_addr, write_data, write_src);
      end
   endtask

   task automatic test_single();
      rst = 1'b0; req_valid = '0;
      set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      #2;
      n_vec++;
      if (req_ready !== 2'b01) begin
         n_err++; $display("FAIL single_ready: req_ready=%b expected 01", req_ready);
      end
      tick();
      req_valid = '0;
      #2;
      n_vec++;
      if (write_enable !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF || write_src !== 1'b0) begin
         n_err++;
         $display("FAIL single_bus: we=%b wa=%0d wd=%h ws=%0d expected 1/5/deadbeef/0",
                  write_enable, write_addr, write_data, write_src);
      end
      tick();
      #2;
      n_vec++;
      if (write_enable !== 1'b0) begin
         n_err++; $display("FAIL single_idle: write_enable=%b expected 0", write_enable);
      end
   endtask

   task automatic test_contention();
      rst = 1'b1;
      set_req(0, 1'b1, 5'd3, 32'h3333_0000);
      set_req(1, 1'b1, 5'd4, 32'h4444_0000);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #2;
         n_vec++;
         if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_err++; $display("FAIL contention_ready[%0d]: req_ready=%b", c, req_ready);
         end
         if (c > 0) begin
            n_vec++;
            if (write_enable !== 1'b1 || write_addr !== ((c % 2 == 1) ? 5'd3 : 5'd4)) begin
               n_err++;
               $display("FAIL contention_bus[%0d]: we=%b wa=%0d", c, write_enable, write_addr);
            end
         end
         tick();
      end
      req_valid = '0;
      #2;
      n_vec++;
      if (write_enable !== 1'b1 || write_addr !== 5'd4 || write_src !== 1'b1) begin
         n_err++;
         $display("FAIL contention_last: we=%b wa=%0d ws=%0d expected 1/4/1", write_enable, write_addr, write_src);
      end
   endtask

   task automatic test_x0();
      req_valid = '0;
      set_req(1, 1'b1, 5'd0, 32'd1);
      #2;
      n_vec++;
      if (req_ready !== 2'b10) begin
         n_err++; $display("FAIL x0_ready: req_ready=%b expected 10", req_ready);
      end
      tick();
      req_valid = '0;
      #2;
      n_vec++;
      if (write_enable !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd1 || write_src !== 1'b1) begin
         n_err++;
         $display("FAIL x0_bus: we=%b wa=%0d wd=%h ws=%0d expected 0/0/1/1",
                  write_enable, write_addr, write_data, write_src);
      end
      set_req(0, 1'b1, 5'd7, 32'h7777);
      set_req(1, 1'b1, 5'd8, 32'h8888);
      #1;
      n_vec++;
      if (req_ready !== 2'b01) begin
         n_err++; $display("FAIL x0_ptr: req_ready=%b expected 01", req_ready);
      end
      tick();
   endtask

   task automatic test_stall();
      logic [NR-1:0] exp_rdy;
      exp_rdy = NR'(1) << m_ptr;
      req_valid = '1;
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         #2;
         n_vec++;
         if (req_ready !== '0 || write_enable !== 1'b0) begin
            n_err++; $display("FAIL stall[%0d]: req_ready=%b we=%b expected 0/0", c, req_ready, write_enable);
         end
      end
      stall = 1'b0;
      #1;
      n_vec++;
      if (req_ready !== exp_rdy) begin
         n_err++; $display("FAIL stall_release: req_ready=%b expected %b", req_ready, exp_rdy);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      int g;
      logic done;
      done = 1'b0;
      set_req(0, 1'b1, 5'd9, 32'h9999);
      set_req(1, 1'b1, 5'd10, 32'hAAAA);
      for (int c = 0; c < NR + 1 && !done; c++) begin
         #2;
         g = model_grant();
         n_vec++;
         if (req_ready !== model_ready()) begin
            n_err++; $display("FAIL midop_ready[%0d]: req_ready=%b expected %b", c, req_ready, model_ready());
         end
         tick();
         if (g == 0) done = 1'b1;
      end
      rst = 1'b1;
      #2;
      n_vec++;
      if (req_ready !== '0 || write_enable !== 1'b1 || write_addr !== 5'd9) begin
         n_err++;
         $display("FAIL midop_rst: req_ready=%b we=%b wa=%0d expected 0/1/9", req_ready, write_enable, write_addr);
      end
      tick();
      rst = 1'b0;
      #2;
      n_vec++;
      if (write_enable !== 1'b0 || req_ready !== 2'b01) begin
         n_err++;
         $display("FAIL midop_after: we=%b req_ready=%b expected 0/01", write_enable, req_ready);
      end
      tick();
      req_valid = '0;
   endtask

   task automatic test_random();
      logic [NR-1:0] pend;
      logic [NR-1:0] exp_rdy;
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 3) != 0) begin
               pend[i] = 1'b1;
               set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom), $urandom);
            end
            req_valid[i] = pend[i];
         end
         stall = ($urandom_range(0, 4) == 0);
         rst   = ($urandom_range(0, 40) == 0);
         #2;
         exp_rdy = model_ready();
         n_vec++;
         if (req_ready !== exp_rdy) begin
            n_err++; $display("FAIL rand_ready[%0d]: req_ready=%b expected %b", c, req_ready, exp_rdy);
         end
         n_vec++;
         if (write_enable !== m_we || write_addr !== m_wa || write_data !== m_wd || write_src !== SW'(m_ws)) begin
            n_err++;
            $display("FAIL rand_bus[%0d]: we=%b wa=%0d wd=%h ws=%0d expected %b/%0d/%h/%0d",
                     c, write_enable, write_addr, write_data, write_src, m_we, m_wa, m_wd, m_ws);
         end
         tick();
         pend = pend & ~exp_rdy;
      end
      rst = 1'b0; stall = 1'b0; req_valid = '0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      #1;
      test_reset();
      test_single();
      test_contention();
      test_x0();
      test_stall();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
